// File: rtl/ljtag_master_if.sv
// Command/response bus of the JTAG initiator.
// master: CPU-side requester. slave: the ljtag_master engine.
interface ljtag_master_if #(
    parameter int MAX_LEN = 32
);
    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic [1:0]         cmd_type_i;
    logic [5:0]         cmd_len_i;
    logic [MAX_LEN-1:0] cmd_data_i;
    logic               rsp_valid_o;
    logic [MAX_LEN-1:0] rsp_data_o;
    logic               busy_o;

    modport master (
        output cmd_valid_i, cmd_type_i, cmd_len_i, cmd_data_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, busy_o
    );

    modport slave (
        input  cmd_valid_i, cmd_type_i, cmd_len_i, cmd_data_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, busy_o
    );
endinterface

// File: rtl/ljtag_master.sv
// JTAG initiator: turns one command (TAP reset, IR shift, DR shift, idle
// clocks) into a complete TAP walk from Run-Test/Idle back to Run-Test/Idle,
// and returns the captured TDO bits as one response.
// Optional build macro LJTAG_TRST_EN adds trst_n_o and a TRST pulse ahead of
// the TMS reset sequence.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command, TCK parked low
// LOAD    | build TMS/TDI/capture bit vectors and the TCK counter
// TRST    | trst_n_o held low for 2*CLK_DIV clocks (LJTAG_TRST_EN only)
// BIT_LO  | TCK low half-period; TMS/TDI updated on entry
// BIT_HI  | TCK high half-period; TDO sampled on first cycle
// DONE    | one-cycle response pulse
module ljtag_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    ljtag_master_if.slave cmd,
    output logic          tck_o,
    output logic          tms_o,
    output logic          tdi_o,
`ifdef LJTAG_TRST_EN
    output logic          trst_n_o,
`endif
    input  logic          tdo_i
);

    // A walk is at most MAX_LEN shift bits plus 6 TAP navigation bits.
    localparam int SEQ_W = MAX_LEN + 6;
    localparam int CNT_W = 7;
    localparam int DIV_W = 9;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_BIT_LO = 3'd2;
    localparam logic [2:0] S_BIT_HI = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
`ifdef LJTAG_TRST_EN
    localparam logic [2:0] S_TRST   = 3'd5;
    localparam logic [DIV_W-1:0] TRST_MAX = DIV_W'(2 * CLK_DIV - 1);
`endif

    localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]         LEN_MAX = 6'(MAX_LEN);
    localparam logic [SEQ_W-1:0]   ONE_W   = SEQ_W'(1);
    localparam logic [MAX_LEN-1:0] ONE_ML  = MAX_LEN'(1);

    logic [2:0]         state;
    logic [1:0]         typ_q;
    logic [5:0]         len_q;
    logic [5:0]         len_eff;
    logic [MAX_LEN-1:0] data_q;

    logic [MAX_LEN-1:0] mask;
    logic [SEQ_W-1:0]   seq_tms, seq_tdi, seq_cap;
    logic [CNT_W-1:0]   seq_cnt;
    logic [SEQ_W-1:0]   tms_sh, tdi_sh, cap_sh;
    logic [SEQ_W-1:0]   src_tms, src_tdi, src_cap;

    logic [CNT_W-1:0]   bit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic               cap_cur;
    logic [5:0]         cap_idx;
    logic [MAX_LEN-1:0] acc, acc_next;
    logic               tdo_m, tdo_s;
    logic               hi_first;
    logic               enter_bit;
    logic               trst_path;

    assign cmd.cmd_ready_o = (state == S_IDLE);
    assign cmd.busy_o      = (state != S_IDLE);
    assign cmd.rsp_valid_o = (state == S_DONE);

`ifdef LJTAG_TRST_EN
    assign trst_path = (typ_q == 2'b00);
`else
    assign trst_path = 1'b0;
`endif

    assign hi_first = (state == S_BIT_HI) && (div_cnt == DIV_MAX);

    // A new TCK bit starts (TMS/TDI update) when leaving LOAD/TRST or after a non-final high phase.
    assign enter_bit = ((state == S_LOAD) && !trst_path)
                    || ((state == S_BIT_HI) && (div_cnt == '0) && (bit_cnt != 7'd1))
`ifdef LJTAG_TRST_EN
                    || ((state == S_TRST) && (div_cnt == '0))
`endif
                    ;

    // Zero length means one bit; anything past the data width is clamped.
    always_comb begin
        if (cmd.cmd_len_i == 6'd0)
            len_eff = 6'd1;
        else if (cmd.cmd_len_i > LEN_MAX)
            len_eff = LEN_MAX;
        else
            len_eff = cmd.cmd_len_i;
    end

    // Build the whole walk as bit vectors, bit 0 = first TCK.
    always_comb begin
        mask    = ~({MAX_LEN{1'b1}} << len_q);
        seq_tms = '0;
        seq_tdi = '0;
        seq_cap = '0;
        seq_cnt = '0;
        case (typ_q)
            2'b00: begin
                seq_tms = SEQ_W'(6'b011111);
                seq_cnt = 7'd6;
            end
            2'b01: begin
                seq_tms = SEQ_W'(2'b11)
                        | (ONE_W << (CNT_W'(len_q) + 7'd3))
                        | (ONE_W << (CNT_W'(len_q) + 7'd4));
                seq_tdi = SEQ_W'(data_q & mask) << 4;
                seq_cap = SEQ_W'(mask) << 4;
                seq_cnt = CNT_W'(len_q) + 7'd6;
            end
            2'b10: begin
                seq_tms = SEQ_W'(1'b1)
                        | (ONE_W << (CNT_W'(len_q) + 7'd2))
                        | (ONE_W << (CNT_W'(len_q) + 7'd3));
                seq_tdi = SEQ_W'(data_q & mask) << 3;
                seq_cap = SEQ_W'(mask) << 3;
                seq_cnt = CNT_W'(len_q) + 7'd5;
            end
            default: begin
                seq_cnt = CNT_W'(len_q);
            end
        endcase
    end

    // The first bit is taken straight from the freshly built vectors.
    always_comb begin
        src_tms = (state == S_LOAD) ? seq_tms : tms_sh;
        src_tdi = (state == S_LOAD) ? seq_tdi : tdi_sh;
        src_cap = (state == S_LOAD) ? seq_cap : cap_sh;
    end

    // Captured TDO merged in on the first high-phase cycle of a shift bit.
    always_comb begin
        acc_next = acc;
        if (hi_first && cap_cur && tdo_s)
            acc_next = acc | (ONE_ML << cap_idx);
    end

    // Two-flop synchroniser for the asynchronous TDO pin.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tdo_m <= 1'b0;
            tdo_s <= 1'b0;
        end else begin
            tdo_m <= tdo_i;
            tdo_s <= tdo_m;
        end
    end

    // Walk sequencer: command latch, half-period timer, TCK and bit counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= S_IDLE;
            typ_q          <= '0;
            len_q          <= '0;
            data_q         <= '0;
            bit_cnt        <= '0;
            div_cnt        <= '0;
            tck_o          <= 1'b0;
            acc            <= '0;
            cap_idx        <= '0;
            cmd.rsp_data_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid_i) begin
                        typ_q   <= cmd.cmd_type_i;
                        len_q   <= len_eff;
                        data_q  <= cmd.cmd_data_i;
                        acc     <= '0;
                        cap_idx <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bit_cnt <= seq_cnt;
`ifdef LJTAG_TRST_EN
                    if (trst_path) begin
                        div_cnt <= TRST_MAX;
                        state   <= S_TRST;
                    end else
`endif
                    begin
                        div_cnt <= DIV_MAX;
                        state   <= S_BIT_LO;
                    end
                end
`ifdef LJTAG_TRST_EN
                S_TRST: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_MAX;
                        state   <= S_BIT_LO;
                    end else begin
                        div_cnt <= div_cnt - 9'd1;
                    end
                end
`endif
                S_BIT_LO: begin
                    if (div_cnt == '0) begin
                        tck_o   <= 1'b1;
                        div_cnt <= DIV_MAX;
                        state   <= S_BIT_HI;
                    end else begin
                        div_cnt <= div_cnt - 9'd1;
                    end
                end
                S_BIT_HI: begin
                    acc <= acc_next;
                    if (hi_first && cap_cur)
                        cap_idx <= cap_idx + 6'd1;
                    if (div_cnt == '0) begin
                        tck_o   <= 1'b0;
                        bit_cnt <= bit_cnt - 7'd1;
                        div_cnt <= DIV_MAX;
                        if (bit_cnt == 7'd1) begin
                            cmd.rsp_data_o <= acc_next;
                            state          <= S_DONE;
                        end else begin
                            state <= S_BIT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt - 9'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // TMS/TDI shifters; pins change only at the start of each TCK low phase.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tms_sh  <= '0;
            tdi_sh  <= '0;
            cap_sh  <= '0;
            tms_o   <= 1'b1;
            tdi_o   <= 1'b0;
            cap_cur <= 1'b0;
        end else begin
            if (state == S_LOAD) begin
                tms_sh <= seq_tms;
                tdi_sh <= seq_tdi;
                cap_sh <= seq_cap;
            end
            if (enter_bit) begin
                tms_o   <= src_tms[0];
                tdi_o   <= src_tdi[0];
                cap_cur <= src_cap[0];
                tms_sh  <= src_tms >> 1;
                tdi_sh  <= src_tdi >> 1;
                cap_sh  <= src_cap >> 1;
            end
        end
    end

`ifdef LJTAG_TRST_EN
    // TRST is asserted during reset and for the TRST state only.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            trst_n_o <= 1'b0;
        else
            trst_n_o <= !(((state == S_LOAD) && trst_path)
                       || ((state == S_TRST) && (div_cnt != '0)));
    end
`endif

endmodule

// File: tb/tb_ljtag_master.sv
// Self-checking bench for ljtag_master: directed walks, boundaries,
// back-pressure, mid-walk reset and randomized commands against a
// sequence-level reference model.
module tb_ljtag_master;
    localparam int CLK_DIV = 4;
    localparam int MAX_LEN = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic tck, tms, tdi, tdo;
`ifdef LJTAG_TRST_EN
    logic trst_n;
`endif

    logic [63:0] tdo_pat = '0;
    logic [63:0] tms_rec = '0;
    logic [63:0] tdi_rec = '0;
    logic [31:0] rsp_last = '0;
    int cyc = 0, n_chk = 0, n_err = 0;
    int tck_cnt = 0, rsp_cnt = 0, idle_viol = 0, trst_low = 0, trst_tck = 0;
    int acc_cyc_q[$];
    int acc_tck_q[$];
    int rsp_cyc_q[$];

    ljtag_master_if #(.MAX_LEN(MAX_LEN)) bus ();

    ljtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .cmd     (bus.slave),
        .tck_o   (tck),
        .tms_o   (tms),
        .tdi_o   (tdi),
`ifdef LJTAG_TRST_EN
        .trst_n_o(trst_n),
`endif
        .tdo_i   (tdo)
    );

    always #5 clk = ~clk;

    // Target TDO: presents pattern bit k during the k-th TCK of a walk.
    assign tdo = tdo_pat[0];
    always @(negedge tck) tdo_pat = tdo_pat >> 1;

    always @(posedge clk) cyc++;

    always @(posedge tck) begin
        tms_rec |= 64'(tms) << tck_cnt;
        tdi_rec |= 64'(tdi) << tck_cnt;
        tck_cnt++;
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                acc_cyc_q.push_back(cyc);
                acc_tck_q.push_back(tck_cnt);
            end
            if (bus.rsp_valid_o) begin
                rsp_cnt++;
                rsp_last = bus.rsp_data_o;
                rsp_cyc_q.push_back(cyc);
            end
            if (!bus.busy_o && tck !== 1'b0) idle_viol++;
`ifdef LJTAG_TRST_EN
            if (trst_n === 1'b0) begin
                trst_low++;
                if (tck_cnt > trst_tck) trst_tck = tck_cnt;
            end
`endif
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the TAP walk written out bit by bit from the command rules.
    task automatic model(input logic [1:0] t, input logic [5:0] len, input logic [31:0] data,
                         input logic [63:0] pat, output int ntck, output logic [63:0] etms,
                         output logic [63:0] etdi, output logic [31:0] ersp);
        int n;
        bit qm[$];
        bit qd[$];
        logic [31:0] dsh;
        logic [63:0] psh;
        n = (len == 0) ? 1 : ((len > 32) ? 32 : int'(len));
        ersp = '0;
        case (t)
            2'b00: begin
                for (int i = 0; i < 5; i++) begin qm.push_back(1); qd.push_back(0); end
                qm.push_back(0); qd.push_back(0);
            end
            2'b11: begin
                for (int i = 0; i < n; i++) begin qm.push_back(0); qd.push_back(0); end
            end
            default: begin
                qm.push_back(1); qd.push_back(0);
                if (t == 2'b01) begin qm.push_back(1); qd.push_back(0); end
                qm.push_back(0); qd.push_back(0);
                qm.push_back(0); qd.push_back(0);
                for (int i = 0; i < n; i++) begin
                    psh = pat >> qm.size();
                    ersp |= 32'(psh[0]) << i;
                    dsh = data >> i;
                    qm.push_back(i == n - 1);
                    qd.push_back(dsh[0]);
                end
                qm.push_back(1); qd.push_back(0);
                qm.push_back(0); qd.push_back(0);
            end
        endcase
        ntck = qm.size();
        etms = '0;
        etdi = '0;
        for (int k = 0; k < ntck; k++) begin
            etms |= 64'(qm[k]) << k;
            etdi |= 64'(qd[k]) << k;
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [5:0] len,
                         input logic [31:0] data);
        bus.cmd_valid_i = v;
        bus.cmd_type_i  = t;
        bus.cmd_len_i   = len;
        bus.cmd_data_i  = data;
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [5:0] len, input logic [31:0] data,
                           input logic [63:0] pat, input string tag);
        int ntck, exp_dur, na, nr, guard;
        logic [63:0] etms, etdi;
        logic [31:0] ersp;
        model(t, len, data, pat, ntck, etms, etdi, ersp);
        exp_dur = 2 + 2 * CLK_DIV * ntck;
`ifdef LJTAG_TRST_EN
        if (t == 2'b00) exp_dur += 2 * CLK_DIV;
`endif
        tdo_pat = pat;
        tck_cnt = 0; tms_rec = '0; tdi_rec = '0; rsp_cnt = 0; trst_low = 0; trst_tck = 0;
        na = acc_cyc_q.size();
        nr = rsp_cyc_q.size();
        @(posedge clk); #1;
        drive(1'b1, t, len, data);
        guard = 0;
        while (acc_cyc_q.size() == na && guard < 100) begin @(posedge clk); guard++; end
        #1;
        drive(1'b0, 2'b00, 6'd0, 32'd0);
        if (acc_cyc_q.size() == na) begin
            chk({tag, "_accept"}, 64'(0), 64'(1));
            return;
        end
        guard = 0;
        while (rsp_cnt == 0 && guard < 4000) begin @(posedge clk); guard++; end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_rsp_cnt"}, 64'(rsp_cnt), 64'(1));
        if (rsp_cnt == 0) return;
        chk({tag, "_tck_cnt"}, 64'(tck_cnt), 64'(ntck));
        chk({tag, "_tms"}, tms_rec, etms);
        chk({tag, "_tdi"}, tdi_rec, etdi);
        chk({tag, "_rsp_data"}, 64'(rsp_last), 64'(ersp));
        chk({tag, "_duration"}, 64'(rsp_cyc_q[nr] - acc_cyc_q[na]), 64'(exp_dur));
        chk({tag, "_ready_after"}, 64'(bus.cmd_ready_o), 64'(1));
        chk({tag, "_tms_park"}, 64'(tms), 64'(0));
`ifdef LJTAG_TRST_EN
        if (t == 2'b00) begin
            chk({tag, "_trst_low"}, 64'(trst_low), 64'(2 * CLK_DIV));
            chk({tag, "_trst_before_tck"}, 64'(trst_tck), 64'(0));
        end
`endif
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 64'(bus.cmd_ready_o), 64'(1));
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'(0));
        chk({tag, "_tck"}, 64'(tck), 64'(0));
        chk({tag, "_tms"}, 64'(tms), 64'(1));
        chk({tag, "_tdi"}, 64'(tdi), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycles=%0d limit=%0d", cyc, 500000);
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nr, guard;
        logic [1:0] rt;
        logic [5:0] rl;
        drive(1'b0, 2'b00, 6'd0, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("in_reset");
        chk("in_reset_rsp_data", 64'(bus.rsp_data_o), 64'(0));
`ifdef LJTAG_TRST_EN
        chk("in_reset_trst", 64'(trst_n), 64'(0));
`endif
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_reset_values("post_reset");
`ifdef LJTAG_TRST_EN
        chk("post_reset_trst", 64'(trst_n), 64'(1));
`endif

        run_cmd(2'b00, 6'd0, $urandom, {$urandom, $urandom}, "tap_reset");
        run_cmd(2'b10, 6'd8, 32'hA5, 64'h3C << 3, "dr8");
        chk("dr8_const_rsp", 64'(rsp_last), 64'h3C);
        run_cmd(2'b01, 6'd5, 32'h1F, {$urandom, $urandom}, "ir5");
        run_cmd(2'b10, 6'd0, 32'hFFFF_FFFF, {$urandom, $urandom}, "dr_len0");
        run_cmd(2'b10, 6'd40, $urandom, {$urandom, $urandom}, "dr_len40");
        run_cmd(2'b11, 6'd3, $urandom, {$urandom, $urandom}, "idle3");

        // Back-pressure: valid held across two idle commands.
        tck_cnt = 0; rsp_cnt = 0;
        na = acc_cyc_q.size();
        nr = rsp_cyc_q.size();
        @(posedge clk); #1;
        drive(1'b1, 2'b11, 6'd2, 32'd0);
        guard = 0;
        while (acc_cyc_q.size() < na + 1 && guard < 100) begin @(posedge clk); guard++; end
        #1;
        bus.cmd_len_i = 6'd3;
        guard = 0;
        while (acc_cyc_q.size() < na + 2 && guard < 400) begin @(posedge clk); guard++; end
        #1;
        drive(1'b0, 2'b00, 6'd0, 32'd0);
        guard = 0;
        while (rsp_cnt < 2 && guard < 400) begin @(posedge clk); guard++; end
        repeat (3) @(posedge clk);
        #1;
        chk("bp_rsp_cnt", 64'(rsp_cnt), 64'(2));
        chk("bp_accept_cnt", 64'(acc_cyc_q.size() - na), 64'(2));
        if (rsp_cnt >= 1 && acc_cyc_q.size() >= na + 2) begin
            chk("bp_second_accept_cycle", 64'(acc_cyc_q[na + 1]), 64'(rsp_cyc_q[nr] + 1));
            chk("bp_no_tck_between", 64'(acc_tck_q[na + 1]), 64'(2));
        end
        chk("bp_total_tck", 64'(tck_cnt), 64'(5));

        for (int i = 0; i < 24; i++) begin
            rt = 2'($urandom_range(0, 3));
            rl = 6'($urandom_range(0, 40));
            run_cmd(rt, rl, $urandom, {$urandom, $urandom}, "rnd");
        end

        // Mid-walk reset during DR shift bit 4 (the 8th TCK).
        tck_cnt = 0; rsp_cnt = 0;
        na = acc_cyc_q.size();
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 6'd8, 32'hFF);
        guard = 0;
        while (acc_cyc_q.size() == na && guard < 100) begin @(posedge clk); guard++; end
        #1;
        drive(1'b0, 2'b00, 6'd0, 32'd0);
        guard = 0;
        while (tck_cnt < 8 && guard < 400) begin @(posedge clk); guard++; end
        chk("abort_reached_bit", 64'(tck_cnt), 64'(8));
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_rsp", 64'(rsp_cnt), 64'(0));
        chk("abort_ready", 64'(bus.cmd_ready_o), 64'(1));
        chk("abort_no_more_tck", 64'(tck_cnt), 64'(8));

        run_cmd(2'b00, 6'd0, 32'd0, {$urandom, $urandom}, "tap_reset2");
        run_cmd(2'b10, 6'd12, $urandom, {$urandom, $urandom}, "dr12");

        chk("idle_tck_low", 64'(idle_viol), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
